// File: rtl/vga_timing_pkg.sv
// Shared SVGA 800x600@60 timing constants, pixel width and memory-owner region type.
// Imported by the timing generator and the frame scheduler.
package vga_timing_pkg;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_TOTAL  = 1056;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_TOTAL  = 628;

  localparam int PIXEL_W = 24;

  typedef enum logic {
    REGION_DISP,
    REGION_HOST
  } region_e;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with region decode.
// All decode outputs are combinational from the current counter values.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_TOTAL  = SVGA_H_TOTAL,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_TOTAL  = SVGA_V_TOTAL,
  parameter int H_W      = $clog2(H_TOTAL),
  parameter int V_W      = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           active,
  output logic           hsync_raw,
  output logic           vsync_raw,
  output logic           frame_first
);

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + V_W'(1);
    end else begin
      h <= h + H_W'(1);
    end
  end

  assign active      = (h < H_ACT) && (v < V_ACT);
  assign hsync_raw   = (h >= HS_BEG) && (h < HS_END);
  assign vsync_raw   = (v >= VS_BEG) && (v < VS_END);
  assign frame_first = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_frame_scheduler.sv
// SVGA output sequencer: owns the image memory, fetching a 4x-upscaled frame during
// active video and granting host writes only in blanking; two-stage output pipeline.
module vga_frame_scheduler
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = SVGA_H_ACTIVE,
  parameter int H_FP        = SVGA_H_FP,
  parameter int H_SYNC      = SVGA_H_SYNC,
  parameter int H_TOTAL     = SVGA_H_TOTAL,
  parameter int V_ACTIVE    = SVGA_V_ACTIVE,
  parameter int V_FP        = SVGA_V_FP,
  parameter int V_SYNC      = SVGA_V_SYNC,
  parameter int V_TOTAL     = SVGA_V_TOTAL,
  parameter int SCALE_SHIFT = 2,
  parameter int IMG_W       = 200,
  parameter int IMG_H       = 150,
  parameter int ADDR_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [PIXEL_W-1:0] mem_wdata,
  input  logic [PIXEL_W-1:0] mem_rdata,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               wr_gnt,
  output logic               wr_err,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               de,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               frame_start
);

  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_LIMIT = ADDR_W'(IMG_W * IMG_H);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           active, hsync_raw, vsync_raw, frame_first;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_TOTAL (H_TOTAL),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_TOTAL (V_TOTAL),
    .H_W      (H_W),      .V_W  (V_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .frame_first (frame_first)
  );

  // Stored image pixel for the current raster position; all arithmetic wraps in ADDR_W bits.
  logic [ADDR_W-1:0] row_idx, col_idx, disp_addr;
  assign row_idx   = ADDR_W'(v >> SCALE_SHIFT);
  assign col_idx   = ADDR_W'(h >> SCALE_SHIFT);
  assign disp_addr = row_idx * IMG_W_A + col_idx;

  region_e            region;
  logic [ADDR_W-1:0]  addr_d;
  logic               rd_d, wr_d, gnt_d, err_d;
  logic [PIXEL_W-1:0] wdata_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    region  = active ? REGION_DISP : REGION_HOST;
    addr_d  = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = '0;
    gnt_d   = 1'b0;
    err_d   = 1'b0;
    if (region == REGION_DISP) begin
      rd_d   = 1'b1;
      addr_d = disp_addr;
    end else if (wr_req && !wr_gnt) begin
      // A grant is never issued two cycles running, giving the host a cycle to advance.
      gnt_d  = 1'b1;
      addr_d = wr_addr;
      if (wr_addr >= IMG_LIMIT) begin
        err_d = 1'b1;
      end else begin
        wr_d    = 1'b1;
        wdata_d = wr_data;
      end
    end
  end

  logic de_s1, hs_s1, vs_s1, fs_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      wr_gnt    <= 1'b0;
      wr_err    <= 1'b0;
      de_s1     <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      fs_s1     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      mem_addr  <= addr_d;
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      mem_wdata <= wdata_d;
      wr_gnt    <= gnt_d;
      wr_err    <= err_d;
      de_s1     <= active;
      hs_s1     <= hsync_raw;
      vs_s1     <= vsync_raw;
      fs_s1     <= frame_first;
    end
  end

  // mem_rdata answers the address presented by stage 1 and is captured here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out   <= '0;
      de          <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pixel_out   <= de_s1 ? mem_rdata : '0;
      de          <= de_s1;
      hsync_n     <= ~hs_s1;
      vsync_n     <= ~vs_s1;
      frame_start <= fs_s1;
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench: a reduced-raster instance checked every cycle against a raster-index model with a
// randomized host, plus a full SVGA instance pinned at a few hand-computed points.
module tb_vga_frame_scheduler;

  localparam int HA = 32, HF = 4, HS = 8, HT = 48;
  localparam int VA = 16, VF = 1, VS = 2, VT = 22;
  localparam int SS = 2, IW = 8, IH = 4, AW = 16;
  localparam int FRAME = HT * VT;
  localparam int FL = 1056;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, f_rst = 1'b1;

  logic [AW-1:0] mem_addr, wr_addr;
  logic          mem_rd, mem_wr, wr_req, wr_gnt, wr_err, de, hsync_n, vsync_n, frame_start;
  logic [23:0]   mem_wdata, mem_rdata, wr_data, pixel_out;

  logic [AW-1:0] f_mem_addr, f_wr_addr;
  logic          f_mem_rd, f_mem_wr, f_wr_req, f_wr_gnt, f_wr_err, f_de, f_hsync_n, f_vsync_n;
  logic          f_frame_start;
  logic [23:0]   f_mem_wdata, f_mem_rdata, f_wr_data, f_pixel_out;

  // Memory model: every location reads back its own address.
  assign mem_rdata   = 24'(mem_addr);
  assign f_mem_rdata = 24'(f_mem_addr);

  vga_frame_scheduler #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_TOTAL (HT),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_TOTAL (VT),
    .SCALE_SHIFT (SS), .IMG_W (IW), .IMG_H (IH), .ADDR_W (AW)
  ) dut (
    .clk (clk), .rst (rst), .mem_addr (mem_addr), .mem_rd (mem_rd), .mem_wr (mem_wr),
    .mem_wdata (mem_wdata), .mem_rdata (mem_rdata), .wr_req (wr_req), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_gnt (wr_gnt), .wr_err (wr_err), .pixel_out (pixel_out),
    .de (de), .hsync_n (hsync_n), .vsync_n (vsync_n), .frame_start (frame_start)
  );

  vga_frame_scheduler dut_full (
    .clk (clk), .rst (f_rst), .mem_addr (f_mem_addr), .mem_rd (f_mem_rd), .mem_wr (f_mem_wr),
    .mem_wdata (f_mem_wdata), .mem_rdata (f_mem_rdata), .wr_req (f_wr_req),
    .wr_addr (f_wr_addr), .wr_data (f_wr_data), .wr_gnt (f_wr_gnt), .wr_err (f_wr_err),
    .pixel_out (f_pixel_out), .de (f_de), .hsync_n (f_hsync_n), .vsync_n (f_vsync_n),
    .frame_start (f_frame_start)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Raster-index model: index n is the n-th pixel clock of the frame sequence since reset.
  function automatic int h_of(input int n); return n % HT; endfunction
  function automatic int v_of(input int n); return (n / HT) % VT; endfunction
  function automatic bit vis(input int n); return h_of(n) < HA && v_of(n) < VA; endfunction
  function automatic int img_addr(input int n);
    return (v_of(n) >> SS) * IW + (h_of(n) >> SS);
  endfunction
  function automatic bit hs_low(input int n);
    return h_of(n) >= HA + HF && h_of(n) < HA + HF + HS;
  endfunction
  function automatic bit vs_low(input int n);
    return v_of(n) >= VA + VF && v_of(n) < VA + VF + VS;
  endfunction

  int            t, ft, p_idx;
  bit            e_rd, e_wr, e_gnt, e_err, g_now;
  logic [AW-1:0] e_addr;
  logic [23:0]   e_wdata;
  int            de_cnt, hs_cnt, vs_cnt, fs_cnt;
  bit            host_rand = 1'b0;
  bit            f_done = 1'b0;

  // Expected stage-1 values for the edge that just happened, from the index that just ended.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; e_rd = 0; e_wr = 0; e_gnt = 0; e_err = 0; e_addr = '0; e_wdata = '0;
    end else begin
      g_now   = !vis(t) && (wr_req === 1'b1) && !e_gnt;
      e_rd    = vis(t);
      e_addr  = vis(t) ? AW'(img_addr(t)) : (g_now ? wr_addr : '0);
      e_gnt   = g_now;
      e_err   = g_now && (int'(wr_addr) >= IW * IH);
      e_wr    = g_now && !e_err;
      e_wdata = e_wr ? wr_data : '0;
      t++;
    end
  end

  always @(posedge clk or posedge f_rst) begin
    if (f_rst) ft = 0;
    else ft++;
  end

  // Per-cycle compare; outputs after edge t show the index t-2 on the display side.
  always @(negedge clk) begin
    if (!rst) begin
      check("mem_rd", mem_rd, e_rd);
      check("mem_wr", mem_wr, e_wr);
      check("wr_gnt", wr_gnt, e_gnt);
      check("wr_err", wr_err, e_err);
      check("strobe_excl", mem_rd & mem_wr, 0);
      if (e_rd || e_wr) check("mem_addr", mem_addr, e_addr);
      if (e_wr) check("mem_wdata", mem_wdata, e_wdata);
      p_idx = t - 2;
      if (p_idx < 0) begin
        check("de_pre", de, 0); check("hsync_n_pre", hsync_n, 1);
        check("vsync_n_pre", vsync_n, 1); check("fs_pre", frame_start, 0);
        check("pixel_pre", pixel_out, 0);
      end else begin
        check("de", de, vis(p_idx));
        check("hsync_n", hsync_n, !hs_low(p_idx));
        check("vsync_n", vsync_n, !vs_low(p_idx));
        check("frame_start", frame_start, (p_idx % FRAME) == 0);
        check("pixel_out", pixel_out, vis(p_idx) ? img_addr(p_idx) : 0);
      end
      if (t == 2) begin de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; end
      if (t >= 2 && t < 2 + FRAME) begin
        de_cnt += int'(de); hs_cnt += int'(!hsync_n);
        vs_cnt += int'(!vsync_n); fs_cnt += int'(frame_start);
      end
      if (t == 2 + FRAME) begin
        check("frame_de_count", de_cnt, 512);
        check("frame_hsync_low", hs_cnt, 176);
        check("frame_vsync_low", vs_cnt, 96);
        check("frame_fs_count", fs_cnt, 1);
        check("frame_fs_period", frame_start, 1);
      end
      if (t == 37)  check("hsync_before", hsync_n, 1);
      if (t == 38)  check("hsync_first", hsync_n, 0);
      if (t == 437) check("pix_3_9", pixel_out, 16);
      if (t == 441) check("pix_7_9", pixel_out, 17);
      if (t == 753) check("pix_last", pixel_out, 31);
      if (t == 754) check("pix_blank", pixel_out, 0);
    end
  end

  always @(negedge clk) begin
    if (host_rand && !rst && (wr_gnt || !wr_req)) begin
      if ($urandom_range(2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(IW * IH + 4));
        wr_data = 24'($urandom);
      end else begin
        wr_req = 1'b0;
      end
    end
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (t != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (t != target) begin
      checks++; errors++;
      $display("FAIL wait_t: at t=%0d, required t=%0d", t, target);
    end
  endtask

  task automatic wait_gnt(input string name, input int limit);
    int n = 0;
    while (wr_gnt !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, wr_gnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);   check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);       check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_wr_gnt"}, wr_gnt, 0);       check({tag, "_wr_err"}, wr_err, 0);
    check({tag, "_pixel"}, pixel_out, 0);     check({tag, "_de"}, de, 0);
    check({tag, "_hsync_n"}, hsync_n, 1);     check({tag, "_vsync_n"}, vsync_n, 1);
    check({tag, "_fs"}, frame_start, 0);
  endtask

  // Full-size instance: literal expectations at the real 800x600 geometry.
  initial begin
    int hs_full = 0, de_full = 0;
    f_wr_req = 1'b0; f_wr_addr = '0; f_wr_data = '0;
    @(negedge clk);
    while (f_rst) @(negedge clk);
    while (ft < 9 * FL + 12) begin
      if (ft >= 2 && ft < 2 + FL) begin
        hs_full += int'(!f_hsync_n);
        de_full += int'(f_de);
      end
      if (ft == 1) check("full_de_before", f_de, 0);
      if (ft == 2) begin
        check("full_first_de", f_de, 1);
        check("full_frame_start", f_frame_start, 1);
      end
      if (ft == 6)   check("full_pix_h4", f_pixel_out, 1);
      if (ft == 841) check("full_hsync_pre", f_hsync_n, 1);
      if (ft == 842) check("full_hsync_start", f_hsync_n, 0);
      if (ft == 969) check("full_hsync_last", f_hsync_n, 0);
      if (ft == 970) check("full_hsync_end", f_hsync_n, 1);
      if (ft == 900) begin
        f_wr_req = 1'b1; f_wr_addr = 16'd30000; f_wr_data = 24'hDEAD01;
      end
      if (ft == 901) begin
        check("full_err_gnt", f_wr_gnt, 1);
        check("full_err_flag", f_wr_err, 1);
        check("full_err_nowr", f_mem_wr, 0);
        f_wr_addr = 16'd29999; f_wr_data = 24'hBEEF02;
      end
      if (ft == 902) check("full_gap", f_wr_gnt, 0);
      if (ft == 903) begin
        check("full_max_gnt", f_wr_gnt, 1);
        check("full_max_err", f_wr_err, 0);
        check("full_max_wr", f_mem_wr, 1);
        check("full_max_addr", f_mem_addr, 29999);
        check("full_max_wdata", f_mem_wdata, 24'hBEEF02);
        f_wr_req = 1'b0;
      end
      if (ft == 9 * FL + 6 + 2) check("full_pix_6_9", f_pixel_out, 401);
      if (ft == 9 * FL + 7 + 2) check("full_pix_7_9", f_pixel_out, 401);
      if (ft == 9 * FL + 8 + 2) check("full_pix_8_9", f_pixel_out, 402);
      @(negedge clk);
    end
    check("full_hsync_per_line", hs_full, 128);
    check("full_de_per_line", de_full, 800);
    f_done = 1'b1;
  end

  initial begin
    int gt[4];
    int gcnt, n_wr, n_rd;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("full_reset_de", f_de, 0);
    check("full_reset_hsync_n", f_hsync_n, 1);
    rst = 1'b0; f_rst = 1'b0;

    // Request raised mid active line waits for the first blanking cycle (h=32).
    wait_t(2 * HT + 10);
    wr_req = 1'b1; wr_addr = 16'd5; wr_data = 24'hABCDEF;
    wait_gnt("held_gnt", 100);
    check("held_gnt_time", t, 2 * HT + HA + 1);
    check("held_wr", mem_wr, 1);
    check("held_addr", mem_addr, 5);
    check("held_wdata", mem_wdata, 24'hABCDEF);
    wr_req = 1'b0;

    // Four back-to-back writes in vertical blanking.
    wait_t(17 * HT + 2);
    gt = '{default: 0};
    gcnt = 0; n_wr = 0; n_rd = 0;
    wr_req = 1'b1; wr_addr = 16'd10; wr_data = 24'($urandom);
    for (int i = 0; i < 20 && gcnt < 4; i++) begin
      @(negedge clk);
      n_wr += int'(mem_wr);
      n_rd += int'(mem_rd);
      if (wr_gnt) begin
        gt[gcnt] = t;
        gcnt++;
        if (gcnt < 4) begin
          wr_addr = AW'(10 + gcnt); wr_data = 24'($urandom);
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    check("stream_grants", gcnt, 4);
    check("stream_wr", n_wr, 4);
    check("stream_rd", n_rd, 0);
    for (int k = 0; k < 4; k++) check("stream_gnt_t", gt[k], 17 * HT + 3 + 2 * k);

    // Address boundary: IW*IH is rejected, IW*IH-1 is written.
    wait_t(18 * HT + 5);
    wr_req = 1'b1; wr_addr = AW'(IW * IH); wr_data = 24'h55AA55;
    @(negedge clk);
    check("err_gnt", wr_gnt, 1);
    check("err_flag", wr_err, 1);
    check("err_nowr", mem_wr, 0);
    wr_addr = AW'(IW * IH - 1); wr_data = 24'h0F0F0F;
    @(negedge clk);
    check("bound_gap", wr_gnt, 0);
    @(negedge clk);
    check("bound_gnt", wr_gnt, 1);
    check("bound_err", wr_err, 0);
    check("bound_wr", mem_wr, 1);
    check("bound_addr", mem_addr, IW * IH - 1);
    check("bound_wdata", mem_wdata, 24'h0F0F0F);
    wr_req = 1'b0;

    host_rand = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    host_rand = 1'b0;
    for (int i = 0; i < 200 && wr_req && !wr_gnt; i++) @(negedge clk);
    wr_req = 1'b0;

    // Asynchronous reset mid active line with a request pending.
    for (int i = 0; i < 2000 && !(h_of(t) == 16 && v_of(t) < VA - 1); i++) @(negedge clk);
    wr_req = 1'b1; wr_addr = 16'd7; wr_data = 24'h123456;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (3) begin
      @(negedge clk);
      check("rst_no_gnt", wr_gnt, 0);
    end
    rst = 1'b0;
    wait_gnt("regrant", 100);
    check("regrant_time", t, HA + 1);
    check("regrant_wr", mem_wr, 1);
    check("regrant_addr", mem_addr, 7);
    check("regrant_wdata", mem_wdata, 24'h123456);
    wr_req = 1'b0;
    repeat (FRAME + 10) @(negedge clk);

    for (int i = 0; i < 20000 && !f_done; i++) @(negedge clk);
    if (!f_done) begin
      checks++; errors++;
      $display("FAIL full_run_timeout: ft=%0d", ft);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
